instr_fetch_responder: RTL and testbench
========================================

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 9, meaning the word-address width (memory depth 2^ADDR_W 16-bit words).
REQ-002 SHALL provide parameter LATENCY, default 4, meaning the stall cycles per demand fetch (legal range 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pc, input, 16 bits: fetch byte address, from the PC register.
REQ-007 SHALL have port instruction, output, 16 bits: fetched instruction for the current pc.
REQ-008 SHALL have port stall, output, 1 bit: high while instruction does not yet correspond to pc; drives the PC register stall input.
REQ-009 SHALL have port instr_valid, output, 1 bit: equal to ~stall.
REQ-010 SHALL have ports ld_en (input, 1 bit), ld_addr (input, ADDR_W bits) and ld_data (input, 16 bits): memory write (load) port.

Function
REQ-011 SHALL derive word index = pc[ADDR_W:1]; pc[0] is ignored, and pc bits above ADDR_W wrap with no error.
REQ-012 SHALL keep registered state req_addr (word index of the last accepted fetch) and an FSM with states BUSY and READY.
REQ-013 stall SHALL be combinational: (state==BUSY) | (pc index != req_addr).
REQ-014 From READY, on pc index != req_addr at edge T: latch req_addr, reload counter, enter BUSY; stall high for exactly LATENCY cycles counted from the first cycle the new pc is visible.
REQ-015 On the final BUSY edge: load instruction from mem[req_addr] and enter READY.
REQ-016 A pc change while BUSY SHALL abort the fetch, relatch req_addr, and restart the full LATENCY count; no stale data is ever presented with stall low.
REQ-017 instruction SHALL hold its last value while stall is high.
REQ-018 ld_en SHALL write mem[ld_addr] on the edge, in any state.
REQ-019 A write to req_addr on the same edge a fetch completes SHALL return ld_data (write bypass).
REQ-020 A write to req_addr during BUSY before completion SHALL be reflected in the returned instruction.
REQ-021 A write to req_addr while READY SHALL NOT update instruction until the next fetch of that word.
REQ-022 The counter SHALL be 4 bits; no overflow is possible for legal LATENCY.

Reset
REQ-023 rst asserted SHALL immediately force: state=BUSY, req_addr=0, counter=LATENCY-1, instruction=16'h0000, stall=1, instr_valid=0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 After rst deassertion, stall SHALL stay high for LATENCY cycles, then instruction = mem[0] (for pc=0).
REQ-026 Reset asserted mid-fetch SHALL discard the fetch.

Configuration
REQ-027 Macro INSTR_PREFETCH_EN, when defined: on entering READY, start a background fetch of req_addr+1 (wrapping modulo 2^ADDR_W) into a prefetch buffer taking LATENCY cycles, with pf_valid set on completion.
REQ-028 With INSTR_PREFETCH_EN, pc index == prefetch address and pf_valid: stall=0 the same cycle, instruction combinationally = prefetch data; next edge promotes the buffer to req_addr and starts the next prefetch.
REQ-029 With INSTR_PREFETCH_EN, pc index == prefetch address while the prefetch is in flight: stall until it completes, without restarting the count.
REQ-030 With INSTR_PREFETCH_EN, any other pc change SHALL abort the prefetch and perform a normal demand fetch.
REQ-031 With INSTR_PREFETCH_EN, a write to the prefetch address SHALL invalidate or refresh the prefetch so that stale data is never returned.
REQ-032 Without INSTR_PREFETCH_EN, no prefetch logic SHALL exist and every pc change costs LATENCY stall cycles.

Verification (LATENCY=4, ADDR_W=9)
REQ-033 Load mem[0]=16'hA123, pulse rst, then pc=0 -> stall high for exactly 4 cycles after release, then instruction=16'hA123 with stall=0.
REQ-034 mem[1]=16'h1111, pc goes 0->2 -> stall rises the same cycle, holds 4 cycles, then instruction=16'h1111; instruction holds 16'hA123 during the stall.
REQ-035 pc 0->2, then 2->8 in the second stall cycle -> count restarts, giving 4 stall cycles after pc=8, then instruction=mem[4].
REQ-036 pc=0x0402 with ADDR_W=9 -> fetches word 1 (wrap); pc=0x0003 -> fetches word 1 (pc[0] ignored).
REQ-037 Fetch of word 5 with ld_en writing word 5 = 16'hBEEF on the completion edge -> instruction=16'hBEEF.
REQ-038 With INSTR_PREFETCH_EN: after word 0 is READY, wait 4 cycles, then pc 0->2 -> stall stays 0 and instruction=mem[1] in the same cycle; pc 2->4 one cycle later -> stall until the in-flight prefetch completes.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: word-addressed 16-bit instruction memory with a fixed fetch latency,
// abort-on-redirect and a load port. Define INSTR_PREFETCH_EN to add a next-word prefetch buffer.
module instr_fetch_responder #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  output logic [15:0]       instruction,
  output logic              stall,
  output logic              instr_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  // The cycle in which a new pc first appears already counts as a stall cycle.
  localparam logic [3:0]  LAT_M2 = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic {StBusy, StReady} state_e;

  state_e            state;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        cnt;
  logic [15:0]       instr_q;
  logic [15:0]       mem [0:DEPTH-1];

  logic [ADDR_W-1:0] idx;
  logic [15:0]       req_rd;
  logic [15:0]       idx_rd;
  logic              demand;
  logic              pf_hit;
  logic              pf_wait;
  logic              unused_pc_bits;

  assign idx            = pc[ADDR_W:1];
  assign unused_pc_bits = ^pc;

  // Reads see a same-edge load so a completing fetch never returns stale data.
  assign req_rd = (ld_en && ld_addr == req_addr) ? ld_data : mem[req_addr];
  assign idx_rd = (ld_en && ld_addr == idx) ? ld_data : mem[idx];

`ifdef INSTR_PREFETCH_EN
  logic [ADDR_W-1:0] pf_addr;
  logic [3:0]        pf_cnt;
  logic              pf_busy;
  logic              pf_valid;
  logic [15:0]       pf_data;
  logic [15:0]       pf_rd;
  logic              start_pf;
  logic [ADDR_W-1:0] pf_base;

  assign pf_rd   = (ld_en && ld_addr == pf_addr) ? ld_data : mem[pf_addr];
  assign pf_hit  = (state == StReady) && (idx != req_addr) && (idx == pf_addr) && pf_valid;
  assign pf_wait = (state == StReady) && (idx != req_addr) && (idx == pf_addr) && pf_busy;

  always_comb begin
    start_pf = 1'b0;
    pf_base  = req_addr;
    if (demand && LATENCY == 1) begin
      start_pf = 1'b1;
      pf_base  = idx;
    end else if (pf_hit) begin
      start_pf = 1'b1;
      pf_base  = pf_addr;
    end else if (!demand && state == StBusy && cnt == '0) begin
      start_pf = 1'b1;
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign pf_wait = 1'b0;
`endif

  assign demand      = (idx != req_addr) && !pf_hit && !pf_wait;
  assign stall       = (state == StBusy) || ((idx != req_addr) && !pf_hit);
  assign instr_valid = ~stall;
`ifdef INSTR_PREFETCH_EN
  assign instruction = pf_hit ? pf_data : instr_q;
`else
  assign instruction = instr_q;
`endif

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StBusy;
      req_addr <= '0;
      cnt      <= LAT_M1;
      instr_q  <= '0;
`ifdef INSTR_PREFETCH_EN
      pf_addr  <= '0;
      pf_cnt   <= '0;
      pf_busy  <= 1'b0;
      pf_valid <= 1'b0;
      pf_data  <= '0;
`endif
    end else begin
`ifdef INSTR_PREFETCH_EN
      if (pf_busy) begin
        if (pf_cnt == '0) begin
          pf_busy  <= 1'b0;
          pf_valid <= 1'b1;
          pf_data  <= pf_rd;
        end else begin
          pf_cnt <= pf_cnt - 4'd1;
        end
      end else if (pf_valid && ld_en && ld_addr == pf_addr) begin
        pf_data <= ld_data;
      end
      if (demand) begin
        pf_busy  <= 1'b0;
        pf_valid <= 1'b0;
      end
      if (start_pf) begin
        pf_addr  <= pf_base + ADDR_W'(1);
        pf_cnt   <= LAT_M1;
        pf_busy  <= 1'b1;
        pf_valid <= 1'b0;
      end
`endif
      // A redirect always restarts the full latency, whether idle or mid-fetch.
      if (demand) begin
        req_addr <= idx;
        if (LATENCY == 1) begin
          instr_q <= idx_rd;
          state   <= StReady;
        end else begin
          cnt   <= LAT_M2;
          state <= StBusy;
        end
      end
`ifdef INSTR_PREFETCH_EN
      else if (pf_hit) begin
        req_addr <= pf_addr;
        instr_q  <= pf_data;
      end
`endif
      else if (state == StBusy) begin
        if (cnt == '0) begin
          instr_q <= req_rd;
          state   <= StReady;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder (default build): directed scenarios plus random
// pc/load traffic against an age-based model of fetch latency.
module tb_instr_fetch_responder;

  localparam int LAT = 4;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   pc;
  logic [15:0]   instruction;
  logic          stall;
  logic          instr_valid;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;

  always #5 clk = ~clk;

  instr_fetch_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .stall      (stall),
    .instr_valid(instr_valid),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  int errors = 0;
  int checks = 0;

  // Model: a word is delivered once its index has been presented for LAT consecutive cycles.
  logic [15:0]   mmem [1 << AW];
  int            age;
  logic [AW-1:0] cur_idx;
  logic [15:0]   exp_instr;
  bit            fresh;

  task automatic drive(input logic [15:0] p, input logic le, input logic [AW-1:0] la,
                       input logic [15:0] ldd);
    logic [AW-1:0] i;
    pc = p; ld_en = le; ld_addr = la; ld_data = ldd;
    i = p[AW:1];
    if (fresh || i != cur_idx) age = 1;
    else age++;
    fresh = 1'b0;
    cur_idx = i;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && age == LAT) exp_instr = (ld_en && ld_addr == cur_idx) ? ld_data : mmem[cur_idx];
    if (ld_en) mmem[ld_addr] = ld_data;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    fresh = 1'b1; exp_instr = '0; age = 0; cur_idx = '0;
    #1;
    checks++;
    if (stall !== 1'b1 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL reset_stall stall=%b valid=%b want 1/0", stall, instr_valid); end
    checks++;
    if (instruction !== 16'h0000)
      begin errors++; $display("FAIL reset_instr got %h want 0000", instruction); end
    for (int i = 0; i < (1 << AW); i++) begin
      ld_en = 1'b1; ld_addr = i[AW-1:0]; ld_data = 16'($urandom);
      tick();
    end
    ld_addr = 9'd0; ld_data = 16'hA123; tick();
    ld_addr = 9'd1; ld_data = 16'h1111; tick();
    ld_en = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || instruction !== 16'h0000)
      begin errors++; $display("FAIL reset_hold stall=%b instr=%h want 1/0000", stall, instruction); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int stalls;
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      drive(16'h0000, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (stall !== (age <= LAT) || instr_valid !== (age > LAT))
        begin errors++; $display("FAIL basic0_stall c=%0d got %b want %b", c, stall, age <= LAT); end
      checks++;
      if (instruction !== exp_instr)
        begin errors++; $display("FAIL basic0_instr c=%0d got %h want %h", c, instruction, exp_instr); end
      if (stall) stalls++;
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== 16'hA123 || stall !== 1'b0)
      begin errors++; $display("FAIL basic0_final stalls=%0d instr=%h want 4/a123", stalls, instruction); end
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      drive(16'h0002, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (stall !== (age <= LAT))
        begin errors++; $display("FAIL basic1_stall c=%0d got %b want %b", c, stall, age <= LAT); end
      if (stall) begin
        stalls++;
        checks++;
        if (instruction !== 16'hA123)
          begin errors++; $display("FAIL basic1_hold c=%0d got %h want a123", c, instruction); end
      end
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== 16'h1111)
      begin errors++; $display("FAIL basic1_final stalls=%0d instr=%h want 4/1111", stalls, instruction); end
  endtask

  task automatic test_abort();
    int stalls;
    for (int c = 0; c < 5; c++) begin drive(16'h0000, 1'b0, '0, '0); tick(); end
    drive(16'h0002, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1)
      begin errors++; $display("FAIL abort_first got %b want 1", stall); end
    tick();
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      drive(16'h0008, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (stall !== (age <= LAT) || instruction !== exp_instr)
        begin errors++; $display("FAIL abort_cycle c=%0d got %b/%h want %b/%h", c, stall,
                                 instruction, age <= LAT, exp_instr); end
      if (stall) stalls++;
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== mmem[4])
      begin errors++; $display("FAIL abort_final stalls=%0d instr=%h want 4/%h", stalls,
                               instruction, mmem[4]); end
  endtask

  task automatic test_wrap();
    int stalls;
    stalls = 0;
    for (int c = 0; c < 6; c++) begin
      drive(16'h0402, 1'b0, '0, '0);
      @(negedge clk);
      if (stall) stalls++;
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== mmem[1])
      begin errors++; $display("FAIL wrap_0402 stalls=%0d instr=%h want 4/%h", stalls,
                               instruction, mmem[1]); end
    for (int c = 0; c < 6; c++) begin drive(16'h0000, 1'b0, '0, '0); tick(); end
    stalls = 0;
    for (int c = 0; c < 6; c++) begin
      drive(16'h0003, 1'b0, '0, '0);
      @(negedge clk);
      if (stall) stalls++;
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== mmem[1])
      begin errors++; $display("FAIL wrap_0003 stalls=%0d instr=%h want 4/%h", stalls,
                               instruction, mmem[1]); end
  endtask

  task automatic test_bypass();
    for (int c = 1; c <= 6; c++)
      begin drive(16'h000A, c == 4, 9'd5, 16'hBEEF); tick(); end
    checks++;
    if (instruction !== 16'hBEEF || stall !== 1'b0)
      begin errors++; $display("FAIL bypass_edge got %h/%b want beef/0", instruction, stall); end
    for (int c = 1; c <= 6; c++)
      begin drive(16'h000C, c == 2, 9'd6, 16'h5A5A); tick(); end
    checks++;
    if (instruction !== 16'h5A5A)
      begin errors++; $display("FAIL bypass_busy got %h want 5a5a", instruction); end
    drive(16'h000C, 1'b1, 9'd6, 16'h0F0F); tick();
    drive(16'h000C, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (instruction !== 16'h5A5A || stall !== 1'b0)
      begin errors++; $display("FAIL ready_write got %h/%b want 5a5a/0", instruction, stall); end
    tick();
    for (int c = 0; c < 6; c++) begin drive(16'h0000, 1'b0, '0, '0); tick(); end
    for (int c = 0; c < 6; c++) begin drive(16'h000C, 1'b0, '0, '0); tick(); end
    checks++;
    if (instruction !== 16'h0F0F)
      begin errors++; $display("FAIL refetch got %h want 0f0f", instruction); end
  endtask

  task automatic test_random();
    logic [15:0]   p;
    logic [AW-1:0] la;
    p = pc;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) p = 16'($urandom);
      la = ($urandom_range(0, 1) == 1) ? p[AW:1] : AW'($urandom);
      drive(p, $urandom_range(0, 2) == 0, la, 16'($urandom));
      @(negedge clk);
      checks++;
      if (stall !== (age <= LAT) || instr_valid !== (age > LAT) || instruction !== exp_instr)
        begin errors++; $display("FAIL random c=%0d got %b/%h want %b/%h", c, stall,
                                 instruction, age <= LAT, exp_instr); end
      tick();
    end
  endtask

  task automatic test_reset_midfetch();
    int stalls;
    for (int c = 0; c < 2; c++) begin drive(16'h0014, 1'b0, '0, '0); tick(); end
    ld_en = 1'b0;
    rst = 1'b1; fresh = 1'b1; exp_instr = '0;
    #1;
    checks++;
    if (stall !== 1'b1 || instr_valid !== 1'b0 || instruction !== 16'h0000)
      begin errors++; $display("FAIL midfetch_rst got %b/%b/%h want 1/0/0000", stall,
                               instr_valid, instruction); end
    tick(); tick();
    rst = 1'b0;
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      drive(16'h0014, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (stall !== (age <= LAT) || instruction !== exp_instr)
        begin errors++; $display("FAIL midfetch_cycle c=%0d got %b/%h want %b/%h", c, stall,
                                 instruction, age <= LAT, exp_instr); end
      if (stall) stalls++;
      tick();
    end
    checks++;
    if (stalls != 4 || instruction !== mmem[10])
      begin errors++; $display("FAIL midfetch_final stalls=%0d instr=%h want 4/%h", stalls,
                               instruction, mmem[10]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_wrap();
    test_bypass();
    test_random();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
